instruction_fetch_unit: RTL

- Sequencer that owns the program counter and drives the combinational instructionMemory read port.
- Prefetches instructions into a small queue and hands them to the decode stage over a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue, and handles halt.
- Sits between the PC logic and decode in the 16-bit CPU.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_queue.sv | 80 ++++++++
 rtl/instruction_fetch_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, FSM encoding, queue entry type and saturating-add helper for the fetch unit.
package fetch_pkg;
  localparam int ADDR_W            = 16;
  localparam int INSTR_W           = 16;
  localparam int DEFAULT_ADDR_STEP = 2;

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef enum logic [1:0] {
    INIT   = ST_INIT,
    FETCH  = ST_FETCH,
    HALTED = ST_HALTED
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// Shift-style prefetch FIFO of {instr, pc}; entry 0 is always the head so it feeds decode from a register.
// With FETCH_PERF_CNT_EN defined, the occupancy is exported as count.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] count
`endif
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     entries     [DEPTH];
  fetch_entry_t     entries_nxt [DEPTH];
  logic [CNT_W-1:0] used;
  logic [CNT_W-1:0] used_nxt;
  logic [CNT_W-1:0] wr_idx;
  logic             pop_ok;
  logic             push_ok;
  logic             shift;

  assign empty   = (used == '0);
  assign full    = (used == CNT_W'(DEPTH));
  assign head    = entries[0];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign wr_idx  = pop_ok ? (used - CNT_W'(1)) : used;
  // A pop of the last entry leaves entry 0 untouched so the head holds its last value.
  assign shift   = pop_ok && (used > CNT_W'(1));
`ifdef FETCH_PERF_CNT_EN
  assign count   = used;
`endif

  // Next queue contents: optional shift toward the head, then write at the tail slot.
  always_comb begin
    entries_nxt = entries;
    for (int i = 0; i < DEPTH - 1; i++) begin
      entries_nxt[i] = shift ? entries[i+1] : entries[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      entries_nxt[i] = (push_ok && (wr_idx == CNT_W'(i))) ? din : entries_nxt[i];
    end
  end

  // Next occupancy.
  always_comb begin
    used_nxt = used;
    case ({push_ok, pop_ok})
      2'b10:   used_nxt = used + CNT_W'(1);
      2'b01:   used_nxt = used - CNT_W'(1);
      default: used_nxt = used;
    endcase
  end

  // Storage and occupancy registers; flush only empties, the stale data is never visible.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      used <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (flush) begin
      used <= '0;
    end else begin
      used    <= used_nxt;
      entries <= entries_nxt;
    end
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer: owns FetchPC, prefetches into fetch_queue and hands instructions to decode.
// Optional FETCH_PERF_CNT_EN adds saturating FetchCount/FlushCount outputs.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'd0,
  parameter int          QUEUE_DEPTH = 2,
  parameter int          ADDR_STEP   = DEFAULT_ADDR_STEP
) (
  input  logic               Clock,
  input  logic               Reset_n,
  output logic [ADDR_W-1:0]  IM_Addr,
  input  logic [INSTR_W-1:0] IM_Data,
  input  logic               Redirect,
  input  logic [ADDR_W-1:0]  RedirectPC,
  input  logic               Halt,
  output logic [INSTR_W-1:0] Instr,
  output logic [ADDR_W-1:0]  InstrPC,
  output logic               InstrValid,
  input  logic               InstrReady
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        FetchCount,
  output logic [15:0]        FlushCount
`endif
);
  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic              redirect_act;
  logic              pop_fire;
  logic              push_fire;
  logic              q_full;
  logic              q_empty;
  fetch_entry_t      q_head;
  fetch_entry_t      push_entry;

  // Redirect is ignored in INIT and otherwise overrides every push/pop on its edge.
  assign redirect_act = Redirect && (state != INIT);
  assign pop_fire     = !q_empty && InstrReady && !redirect_act;
  assign push_fire    = (state == FETCH) && !Halt && !redirect_act && (!q_full || pop_fire);
  assign push_entry   = '{instr: IM_Data, pc: fetch_pc};

  assign IM_Addr    = fetch_pc;
  assign Instr      = q_head.instr;
  assign InstrPC    = q_head.pc;
  assign InstrValid = !q_empty;

`ifdef FETCH_PERF_CNT_EN
  logic [$clog2(QUEUE_DEPTH+1)-1:0] q_count;
`endif

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clock (Clock),
    .rst_n (Reset_n),
    .push  (push_fire),
    .pop   (pop_fire),
    .flush (redirect_act),
    .din   (push_entry),
    .full  (q_full),
    .empty (q_empty),
    .head  (q_head)
`ifdef FETCH_PERF_CNT_EN
    ,
    .count (q_count)
`endif
  );

  // Next-state logic; HALTED is left only by a redirect.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        if (redirect_act) begin
          state_nxt = FETCH;
        end else if (Halt) begin
          state_nxt = HALTED;
        end else begin
          state_nxt = FETCH;
        end
      end
      HALTED: begin
        if (redirect_act) begin
          state_nxt = FETCH;
        end else begin
          state_nxt = HALTED;
        end
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  // State and program counter registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= INIT;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (redirect_act) begin
        fetch_pc <= {RedirectPC[ADDR_W-1:1], 1'b0};
      end else if (push_fire) begin
        fetch_pc <= fetch_pc + ADDR_W'(ADDR_STEP);
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating performance counters.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      FetchCount <= 16'd0;
      FlushCount <= 16'd0;
    end else begin
      if (push_fire) begin
        FetchCount <= sat_add16(FetchCount, 16'd1);
      end
      if (redirect_act) begin
        FlushCount <= sat_add16(FlushCount, 16'(q_count));
      end
    end
  end
`endif
endmodule
